// File: rtl/rip_const.sv
// Shared constants for the rip_lsu load/store unit: access sizes, FSM states,
// byte-lane masks and the misalignment rule.
package rip_const;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    RSP  = 2'd3
  } lsu_state_t;

  localparam logic [3:0] SIZE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_MASK_HALF = 4'b0011;
  localparam logic [3:0] SIZE_MASK_WORD = 4'b1111;

  // An access is misaligned when it crosses a word boundary.
  function automatic logic is_misaligned(mem_size_t size, logic [1:0] off);
    return ((size == SIZE_WORD) && (off != 2'd0)) ||
           ((size == SIZE_HALF) && (off == 2'd3));
  endfunction

endpackage

// File: rtl/rip_lsu_align.sv
// Combinational lane steering for rip_lsu: store shift/strobe generation over a
// two-word window, and load shift plus sign/zero extension.
module rip_lsu_align
  import rip_const::*;
#(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  mem_size_t                 st_size,
  input  logic [1:0]                st_off,
  input  logic [DATA_WIDTH-1:0]     st_wdata,
  output logic [2*DATA_WIDTH-1:0]   st_data,
  output logic [2*NUM_COL-1:0]      st_strb,
  input  mem_size_t                 ld_size,
  input  logic                      ld_unsigned,
  input  logic [1:0]                ld_off,
  input  logic [DATA_WIDTH-1:0]     ld_beat0,
  input  logic [DATA_WIDTH-1:0]     ld_beat1,
  output logic [DATA_WIDTH-1:0]     ld_data
);

  logic [DATA_WIDTH-1:0] st_sized;
  logic [NUM_COL-1:0]    st_mask;
  logic [DATA_WIDTH-1:0] ld_low;
  logic                  ld_sign;

  always_comb begin
    st_sized = '0;
    st_mask  = '0;
    case (st_size)
      SIZE_BYTE: begin
        st_sized[COL_WIDTH-1:0] = st_wdata[COL_WIDTH-1:0];
        st_mask                 = NUM_COL'(SIZE_MASK_BYTE);
      end
      SIZE_HALF: begin
        st_sized[2*COL_WIDTH-1:0] = st_wdata[2*COL_WIDTH-1:0];
        st_mask                   = NUM_COL'(SIZE_MASK_HALF);
      end
      SIZE_WORD: begin
        st_sized = st_wdata;
        st_mask  = NUM_COL'(SIZE_MASK_WORD);
      end
      default: ;
    endcase
    st_data = {{DATA_WIDTH{1'b0}}, st_sized} << (st_off * COL_WIDTH);
    st_strb = {{NUM_COL{1'b0}}, st_mask} << st_off;
  end

  // Bytes shifted past the low word of the window belong to no result.
  always_comb begin
    ld_low  = DATA_WIDTH'({ld_beat1, ld_beat0} >> (ld_off * COL_WIDTH));
    ld_sign = 1'b0;
    ld_data = '0;
    case (ld_size)
      SIZE_BYTE: begin
        ld_sign = ld_low[COL_WIDTH-1] & ~ld_unsigned;
        ld_data = {{(DATA_WIDTH-COL_WIDTH){ld_sign}}, ld_low[COL_WIDTH-1:0]};
      end
      SIZE_HALF: begin
        ld_sign = ld_low[2*COL_WIDTH-1] & ~ld_unsigned;
        ld_data = {{(DATA_WIDTH-2*COL_WIDTH){ld_sign}}, ld_low[2*COL_WIDTH-1:0]};
      end
      SIZE_WORD: ld_data = ld_low;
      default:   ld_data = '0;
    endcase
  end

endmodule

// File: rtl/rip_lsu.sv
// Load/store unit driving the data-memory port. Define RIP_LSU_MISALIGNED_EN to
// split misaligned accesses into two beats; otherwise they return rsp_err.
module rip_lsu
  import rip_const::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  mem_size_t             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_en_q, mem_en_d;
  logic [NUM_COL-1:0]    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
`ifdef RIP_LSU_MISALIGNED_EN
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  split;
`endif

  mem_size_t               req_size_e, st_size;
  logic [1:0]              st_off;
  logic [DATA_WIDTH-1:0]   st_wdata, ld_beat0, ld_beat1, ld_data;
  logic [2*DATA_WIDTH-1:0] st_data;
  logic [2*NUM_COL-1:0]    st_strb;
  logic                    accept, req_bad;

  assign req_size_e = mem_size_t'(req_size);
  assign req_ready  = ((state_q == IDLE) || (state_q == RSP)) && rstn;
  assign accept     = req_valid && req_ready;

  // Beat 0 lanes come from the live request; beat 1 lanes from the latched one.
  always_comb begin
    if (state_q == B0) begin
      st_size  = size_q;
      st_off   = off_q;
      st_wdata = wdata_q;
    end else begin
      st_size  = req_size_e;
      st_off   = req_addr[1:0];
      st_wdata = req_wdata;
    end
`ifdef RIP_LSU_MISALIGNED_EN
    split    = is_misaligned(size_q, off_q);
    req_bad  = (req_size_e == SIZE_RSVD);
    ld_beat0 = split ? lo_q : mem_rdata;
    ld_beat1 = split ? mem_rdata : '0;
`else
    req_bad  = (req_size_e == SIZE_RSVD) || is_misaligned(req_size_e, req_addr[1:0]);
    ld_beat0 = mem_rdata;
    ld_beat1 = '0;
`endif
  end

  rip_lsu_align #(
    .NUM_COL   (NUM_COL),
    .COL_WIDTH (COL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .st_size    (st_size),
    .st_off     (st_off),
    .st_wdata   (st_wdata),
    .st_data    (st_data),
    .st_strb    (st_strb),
    .ld_size    (size_q),
    .ld_unsigned(uns_q),
    .ld_off     (off_q),
    .ld_beat0   (ld_beat0),
    .ld_beat1   (ld_beat1),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
`ifdef RIP_LSU_MISALIGNED_EN
    waddr_d     = waddr_q;
    lo_d        = lo_q;
`endif
    case (state_q)
      IDLE, RSP: begin
        state_d = IDLE;
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size_e;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
`ifdef RIP_LSU_MISALIGNED_EN
          waddr_d = req_addr[ADDR_WIDTH+1:2];
`endif
          if (req_bad) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = B0;
            mem_en_d    = 1'b1;
            mem_addr_d  = req_addr[ADDR_WIDTH+1:2];
            mem_we_d    = req_we ? st_strb[NUM_COL-1:0] : '0;
            mem_wdata_d = req_we ? st_data[DATA_WIDTH-1:0] : '0;
          end
        end
      end
      B0: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
`ifdef RIP_LSU_MISALIGNED_EN
        if (split) begin
          state_d     = B1;
          rsp_valid_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = waddr_q + ADDR_WIDTH'(1);
          mem_we_d    = we_q ? st_strb[2*NUM_COL-1:NUM_COL] : '0;
          mem_wdata_d = we_q ? st_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        end
`endif
      end
`ifdef RIP_LSU_MISALIGNED_EN
      B1: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        lo_d        = mem_rdata;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef RIP_LSU_MISALIGNED_EN
      waddr_q     <= '0;
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`ifdef RIP_LSU_MISALIGNED_EN
      waddr_q     <= waddr_d;
      lo_q        <= lo_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = ((state_q == RSP) && !we_q && !rsp_err_q) ? ld_data : '0;

endmodule

// File: tb/tb_rip_lsu.sv
// Directed self-checking bench for rip_lsu with a behavioural one-cycle-latency
// data memory; the split-access tests follow RIP_LSU_MISALIGNED_EN.
module tb_rip_lsu;

  logic        clk, rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        bd_we;
  logic [19:0] bd_addr;
  logic [31:0] bd_data;
  bit   [31:0] mem [0:(1<<20)-1];

  int checks = 0;
  int errors = 0;

  rip_lsu #(.ADDR_WIDTH(20), .NUM_COL(4), .COL_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic preload(input logic [19:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %h, expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %h, expected 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_err: got %h, expected 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rsp_rdata: got %h, expected 0", rsp_rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_en: got %h, expected 0", mem_en); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("[TB] FAIL rst_mem_we: got %h, expected 0", mem_we); end
    checks++; if (mem_addr !== 20'h0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h, expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_wdata: got %h, expected 0", mem_wdata); end
    rstn = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %h, expected 1", req_ready); end
  endtask

  task automatic test_store_word;
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL sw_mem_en: got %h, expected 1", mem_en); end
    checks++; if (mem_addr !== 20'h40) begin errors++; $display("[TB] FAIL sw_mem_addr: got %h, expected 40", mem_addr); end
    checks++; if (mem_we !== 4'hF) begin errors++; $display("[TB] FAIL sw_mem_we: got %h, expected f", mem_we); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_mem_wdata: got %h, expected deadbeef", mem_wdata); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_early_rsp: got %h, expected 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL sw_rsp_valid: got %h, expected 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL sw_rsp_err: got %h, expected 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL sw_rsp_rdata: got %h, expected 0", rsp_rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL sw_mem_en_off: got %h, expected 0", mem_en); end
    checks++; if (mem[20'h40] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_mem_content: got %h, expected deadbeef", mem[20'h40]); end
  endtask

  task automatic test_store_sub;
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFFAB);
    @(negedge clk);
    checks++; if (mem_we !== 4'b0010) begin errors++; $display("[TB] FAIL sb_mem_we: got %b, expected 0010", mem_we); end
    checks++; if (mem_wdata !== 32'h0000AB00) begin errors++; $display("[TB] FAIL sb_mem_wdata: got %h, expected 0000ab00", mem_wdata); end
    @(negedge clk);
    issue(1'b1, 2'd1, 1'b0, 32'h102, 32'hCAFE1234);
    @(negedge clk);
    checks++; if (mem_we !== 4'b1100) begin errors++; $display("[TB] FAIL sh_mem_we: got %b, expected 1100", mem_we); end
    checks++; if (mem_wdata !== 32'h12340000) begin errors++; $display("[TB] FAIL sh_mem_wdata: got %h, expected 12340000", mem_wdata); end
    @(negedge clk);
    checks++; if (mem[20'h40] !== 32'h1234ABEF) begin errors++; $display("[TB] FAIL sub_mem_content: got %h, expected 1234abef", mem[20'h40]); end
  endtask

  task automatic test_load_extend;
    logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        un  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000, 32'h80000000};
    preload(20'h40, 32'h80000000);
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, sz[i], un[i], ad[i], 32'hFFFFFFFF);
      @(negedge clk);
      checks++; if (mem_we !== 4'h0) begin errors++; $display("[TB] FAIL ld%0d_mem_we: got %h, expected 0", i, mem_we); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ld%0d_rsp_valid: got %h, expected 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== exp[i]) begin errors++; $display("[TB] FAIL ld%0d_rdata: got %h, expected %h", i, rsp_rdata, exp[i]); end
    end
  endtask

  task automatic test_reserved;
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rsvd_mem_en: got %h, expected 0", mem_en); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rsvd_rsp_valid: got %h, expected 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL rsvd_rsp_err: got %h, expected 1", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rsvd_rsp_rdata: got %h, expected 0", rsp_rdata); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsvd_rsp_pulse: got %h, expected 0", rsp_valid); end
  endtask

`ifdef RIP_LSU_MISALIGNED_EN
  task automatic test_misaligned;
    issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h00001234);
    @(negedge clk);
    checks++; if (mem_addr !== 20'h40) begin errors++; $display("[TB] FAIL spl_sh_addr0: got %h, expected 40", mem_addr); end
    checks++; if (mem_we !== 4'b1000) begin errors++; $display("[TB] FAIL spl_sh_we0: got %b, expected 1000", mem_we); end
    checks++; if (mem_wdata !== 32'h34000000) begin errors++; $display("[TB] FAIL spl_sh_wdata0: got %h, expected 34000000", mem_wdata); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL spl_sh_en1: got %h, expected 1", mem_en); end
    checks++; if (mem_addr !== 20'h41) begin errors++; $display("[TB] FAIL spl_sh_addr1: got %h, expected 41", mem_addr); end
    checks++; if (mem_we !== 4'b0001) begin errors++; $display("[TB] FAIL spl_sh_we1: got %b, expected 0001", mem_we); end
    checks++; if (mem_wdata !== 32'h00000012) begin errors++; $display("[TB] FAIL spl_sh_wdata1: got %h, expected 00000012", mem_wdata); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL spl_sh_early_rsp: got %h, expected 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL spl_sh_rsp: got %h, expected 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL spl_sh_err: got %h, expected 0", rsp_err); end
    preload(20'h40, 32'h11223344);
    preload(20'h41, 32'h55667788);
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++; if (mem_addr !== 20'h41) begin errors++; $display("[TB] FAIL spl_lw_addr1: got %h, expected 41", mem_addr); end
    @(negedge clk);
    checks++; if (rsp_rdata !== 32'h77881122) begin errors++; $display("[TB] FAIL spl_lw_rdata: got %h, expected 77881122", rsp_rdata); end
    preload(20'hFFFFF, 32'hAABBCCDD);
    preload(20'h00000, 32'h01020304);
    issue(1'b0, 2'd2, 1'b0, 32'h003FFFFF, 32'h0);
    @(negedge clk);
    checks++; if (mem_addr !== 20'hFFFFF) begin errors++; $display("[TB] FAIL wrap_addr0: got %h, expected fffff", mem_addr); end
    @(negedge clk);
    checks++; if (mem_addr !== 20'h00000) begin errors++; $display("[TB] FAIL wrap_addr1: got %h, expected 00000", mem_addr); end
    @(negedge clk);
    checks++; if (rsp_rdata !== 32'h020304AA) begin errors++; $display("[TB] FAIL wrap_rdata: got %h, expected 020304aa", rsp_rdata); end
  endtask
`else
  task automatic test_misaligned;
    issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_mem_en: got %h, expected 0", mem_en); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mis_lw_rsp_valid: got %h, expected 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_lw_rsp_err: got %h, expected 1", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mis_lw_rdata: got %h, expected 0", rsp_rdata); end
    issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h1234);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL mis_sh_mem_en: got %h, expected 0", mem_en); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_sh_rsp_err: got %h, expected 1", rsp_err); end
  endtask
`endif

  task automatic test_back_to_back;
    preload(20'h40, 32'hCAFEF00D);
    preload(20'h41, 32'h0BADBEEF);
    @(posedge clk); #1;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_size = 2'd1; req_unsigned = 1'b1; req_addr = 32'h106;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_b0: got %h, expected 0", req_ready); end
    checks++; if (mem_addr !== 20'h40) begin errors++; $display("[TB] FAIL b2b_addr_first: got %h, expected 40", mem_addr); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_rsp: got %h, expected 1", req_ready); end
    checks++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_rdata_first: got %h, expected cafef00d", rsp_rdata); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_en_second: got %h, expected 1", mem_en); end
    checks++; if (mem_addr !== 20'h41) begin errors++; $display("[TB] FAIL b2b_addr_second: got %h, expected 41", mem_addr); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rsp_second: got %h, expected 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h00000BAD) begin errors++; $display("[TB] FAIL b2b_rdata_second: got %h, expected 00000bad", rsp_rdata); end
  endtask

  task automatic test_reset_mid;
`ifdef RIP_LSU_MISALIGNED_EN
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    @(posedge clk);
`else
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
`endif
    #2 rstn = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_mem_en: got %h, expected 0", mem_en); end
    checks++; if (mem_addr !== 20'h0) begin errors++; $display("[TB] FAIL mid_mem_addr: got %h, expected 0", mem_addr); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp_valid: got %h, expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got %h, expected 0", req_ready); end
    @(negedge clk);
    rstn = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready_release: got %h, expected 1", req_ready); end
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_rsp: got %h, expected 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL mid_after_rdata: got %h, expected cafef00d", rsp_rdata); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_store_word();
    test_store_sub();
    test_load_extend();
    test_reserved();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rip_lsu.md
# rip_lsu

Load/store unit: the initiator side of the CPU's data-memory port. Accepts one load/store request at a time from the MA stage, issues word-addressed, byte-strobed accesses to the data memory (one-cycle read latency), and returns aligned, sign- or zero-extended load data. Misaligned accesses are split into two word beats; this can be compiled out, in which case they are reported as errors.

## Interface
- ADDR_WIDTH, 20, word-address width of the memory port
- NUM_COL, 4, byte lanes per word
- COL_WIDTH, 8, bits per lane
- DATA_WIDTH, NUM_COL*COL_WIDTH, data width
- clk  in  1  clock; single clock domain
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  mem_size_t: 0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request
- mem_en  out  1  memory access this cycle
- mem_we  out  NUM_COL  byte write strobes
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  lane-positioned write data
- mem_rdata  in  DATA_WIDTH  read word; valid the cycle after mem_en

## Operation
- States: IDLE, B0, B1, RSP.
- req_ready = (state is IDLE or RSP) & rstn. Acceptance latches we, size, unsigned, addr, and wdata.
- Accept -> B0, or -> RSP with rsp_err if the request is illegal.
- B0: mem_en=1, mem_addr=addr[ADDR_WIDTH+1:2], first beat. If split -> B1, else -> RSP.
- B1: mem_en=1, mem_addr=(word addr+1) mod 2^ADDR_WIDTH, second beat. The beat-0 mem_rdata is captured into a low-word register. Next state is RSP.
- RSP: rsp_valid=1. Next state is B0 or RSP on a new accept, otherwise IDLE.
- Misaligned: a word with addr[1:0]≠0, or a half with addr[1:0]=3.
- Store lanes: form the 2-word value {0,wdata_sized}<<(off*8) and the strobe size_mask<<off (8 bits). Beat 0 uses the low halves, beat 1 the high halves. size_mask is 0001/0011/1111. mem_we=0 on loads.
- Load assembly: {beat1,beat0}>>(off*8), then truncate to size and extend per req_unsigned. rsp_rdata is combinational from mem_rdata (and the low-word register) in RSP.
- Address bits above ADDR_WIDTH+1 are ignored.
- A store's rsp_rdata is 0, and its response still follows the beats.
- Reserved size (3): no memory access; RSP with rsp_err=1.
- Reset mid-operation: returns to IDLE immediately. No rollback: a beat-0 store already written stays written.

## Timing
- Accept at cycle A.
- Aligned load/store: mem_en at A+1, rsp_valid at A+2.
- Split: mem_en at A+1 and A+2, rsp_valid at A+3.
- Error: no mem_en, rsp_valid at A+1.
- Back-to-back: an accept during RSP drives B0 in the next cycle, giving peak throughput of one aligned access every 2 cycles.
- Reset values: state IDLE; rsp_valid, rsp_err, mem_en, and mem_we all 0; mem_addr, mem_wdata, and rsp_rdata 0; req_ready 0 while rstn is low.

## Configuration
- RIP_LSU_MISALIGNED_EN defined: split handling as above.
- Undefined: B1 and the low-word register are removed. A misaligned request goes straight to RSP with rsp_err=1 and rsp_rdata=0, and never asserts mem_en.

## Structure
- The mem_size_t and lsu_state_t enums, and the size-mask constants, go in the shared rip_const package.
- One combinational sub-module, rip_lsu_align, handles store shift/strobe generation and load shift/extension. The FSM and registers stay in rip_lsu.

## Test plan
- SW 0xDEADBEEF @0x100 -> A+1: mem_en=1, mem_addr=0x40, mem_we=1111, mem_wdata=0xDEADBEEF; A+2: rsp_valid=1, rsp_err=0.
- Word 0x80000000 @0x40; LB @0x103 -> rsp_rdata=0xFFFFFF80 at A+2; LBU @0x103 -> 0x00000080.
- (EN) SH 0x1234 @0x103 -> A+1: addr 0x40, we=1000, wdata[31:24]=0x34; A+2: addr 0x41, we=0001, wdata[7:0]=0x12; rsp at A+3.
- (EN) 0x11223344 @0x40, 0x55667788 @0x41; LW @0x102 -> rsp_rdata=0x77881122 at A+3. LW @0xFFFFF (top word, off 3) -> beat 1 at mem_addr 0x00000.
- (not EN) LW @0x101 -> no mem_en; A+1: rsp_valid=1, rsp_err=1, rsp_rdata=0. Any build: req_size=3 -> same response.
- rstn low during B1 -> all outputs 0 immediately; after release, req_ready=1 and the next LW @0x100 completes normally at A+2.
